// File: rtl/wt_dcache_rd_miss_unit.sv
// -----------------------------------------------------------------------------
// wt_dcache_rd_miss_unit
//
// Purpose:
//   Serves one read miss at a time for the write-through dcache. It accepts a
//   miss from the read controller, or asks it to replay when a pending store
//   targets the same index. It picks a victim way and issues the memory read.
//   On the matching return it pulses miss_rtrn_vld_o with the requested 64-bit
//   word and, for cacheable misses, writes the refill line into the cache.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   miss_*_i / miss_*_o   read-controller miss handshake (ack/replay pulses),
//                         request fields and the miss-return word
//   wr_pend_vld_i/idx_i   outstanding store on the write path (collision check)
//   mem_*_o / mem_ack_i   memory request, held until acknowledged
//   mem_rtrn_*_i          memory return (ID-filtered)
//   wr_cl_*_o             refill write into the tag/data arrays
//
// Optional feature (macro WT_DCACHE_RD_MISS_PERF_EN):
//   Adds perf_miss_cnt_o and perf_replay_cnt_o, saturating 32-bit counters of
//   accepted misses and replay pulses. Without the macro neither the ports nor
//   the counters exist.
// -----------------------------------------------------------------------------
module wt_dcache_rd_miss_unit #(
  parameter int unsigned             CacheIdWidth     = 2,
  parameter logic [CacheIdWidth-1:0] RdTxId           = CacheIdWidth'(1),
  parameter int unsigned             NumWays          = 4,
  parameter int unsigned             LineWidth        = 128,
  parameter int unsigned             SigWidth         = 14,
  parameter int unsigned             DcacheClIdxWidth = 8,
  parameter int unsigned             DcacheTagWidth   = 44
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // read controller
  input  logic                        miss_req_i,
  output logic                        miss_ack_o,
  output logic                        miss_replay_o,
  input  logic [63:0]                 miss_paddr_i,
  input  logic                        miss_nc_i,
  input  logic [2:0]                  miss_size_i,
  input  logic [CacheIdWidth-1:0]     miss_id_i,
  input  logic [NumWays-1:0]          miss_vld_bits_i,
  input  logic [NumWays-1:0]          miss_ever_hit_i,
  input  logic [SigWidth-1:0]         miss_signature_i,
  output logic                        miss_rtrn_vld_o,
  output logic [63:0]                 miss_rtrn_data_o,
  // write path
  input  logic                        wr_pend_vld_i,
  input  logic [DcacheClIdxWidth-1:0] wr_pend_idx_i,
  // memory adapter
  output logic                        mem_req_o,
  input  logic                        mem_ack_i,
  output logic [63:0]                 mem_paddr_o,
  output logic [2:0]                  mem_size_o,
  output logic                        mem_nc_o,
  output logic [CacheIdWidth-1:0]     mem_id_o,
  input  logic                        mem_rtrn_vld_i,
  input  logic [CacheIdWidth-1:0]     mem_rtrn_id_i,
  input  logic [LineWidth-1:0]        mem_rtrn_data_i,
  // refill into the cache arrays
  output logic                        wr_cl_vld_o,
  output logic [NumWays-1:0]          wr_cl_way_o,
  output logic [DcacheClIdxWidth-1:0] wr_cl_idx_o,
  output logic [DcacheTagWidth-1:0]   wr_cl_tag_o,
  output logic [SigWidth-1:0]         wr_cl_sig_o,
  output logic [LineWidth-1:0]        wr_cl_data_o
`ifdef WT_DCACHE_RD_MISS_PERF_EN
  ,
  output logic [31:0]                 perf_miss_cnt_o,
  output logic [31:0]                 perf_replay_cnt_o
`endif
);

  localparam int unsigned OffWidth     = $clog2(LineWidth / 8);
  localparam int unsigned WordSelWidth = OffWidth - 3;
  localparam int unsigned PtrWidth     = $clog2(NumWays);
  localparam int unsigned TagLsb       = OffWidth + DcacheClIdxWidth;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  logic [1:0]          state_reg, state_next;
  logic [PtrWidth-1:0] rr_ptr_reg, rr_ptr_next;

  // request captured at ack time
  logic [63:0]         paddr_reg;
  logic                nc_reg;
  logic [2:0]          size_reg;
  logic [SigWidth-1:0] sig_reg;
  logic [NumWays-1:0]  way_reg;

  logic collide, ack, replay, rtrn_hit, refill;

  // The request ID carries no information for this unit: there is only one
  // read transaction ID and it is always used on the memory side.
  logic unused_id;
  assign unused_id = ^miss_id_i;

  // ---------------------------------------------------------------------------
  // Accept / replay decision
  // ---------------------------------------------------------------------------
  // A cacheable miss may not refill an index that a store is still writing,
  // otherwise the refill could overwrite freshly stored data. NC misses never
  // touch the arrays, so they are not held back.
  assign collide = !miss_nc_i && wr_pend_vld_i &&
                   (wr_pend_idx_i == miss_paddr_i[OffWidth +: DcacheClIdxWidth]);
  assign ack     = !rst_i && (state_reg == IDLE) && miss_req_i && !collide;
  assign replay  = !rst_i && (state_reg == IDLE) && miss_req_i &&  collide;

  assign miss_ack_o    = ack;
  assign miss_replay_o = replay;

  // ---------------------------------------------------------------------------
  // Victim selection: first invalid way, else first never-hit way, else the
  // round-robin way. x & -x isolates the lowest set bit of x.
  // ---------------------------------------------------------------------------
  logic [NumWays-1:0] inv_mask, nohit_mask, inv_oh, nohit_oh, rr_oh, victim_oh;
  logic               use_rr;

  assign inv_mask   = ~miss_vld_bits_i;
  assign nohit_mask = ~miss_ever_hit_i;
  assign inv_oh     = inv_mask   & (~inv_mask   + NumWays'(1));
  assign nohit_oh   = nohit_mask & (~nohit_mask + NumWays'(1));

  genvar gi;
  generate
    for (gi = 0; gi < NumWays; gi++) begin : g_rr_oh
      assign rr_oh[gi] = (rr_ptr_reg == PtrWidth'(gi));
    end
  endgenerate

  always_comb begin
    victim_oh = rr_oh;
    use_rr    = 1'b0;
    if (|inv_mask) begin
      victim_oh = inv_oh;
    end else if (|nohit_mask) begin
      victim_oh = nohit_oh;
    end else begin
      use_rr = 1'b1;
    end
  end

  // The pointer only moves when it actually chose a line to evict.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (ack && use_rr && !miss_nc_i) begin
      rr_ptr_next = (rr_ptr_reg == PtrWidth'(NumWays - 1)) ? '0
                                                           : rr_ptr_reg + PtrWidth'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // A return in the same cycle as mem_ack_i is still in MEM_REQ and is dropped.
  assign rtrn_hit = !rst_i && (state_reg == MEM_WAIT) && mem_rtrn_vld_i &&
                    (mem_rtrn_id_i == RdTxId);
  assign refill   = rtrn_hit && !nc_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (ack)       state_next = MEM_REQ;
      MEM_REQ:  if (mem_ack_i) state_next = MEM_WAIT;
      MEM_WAIT: if (rtrn_hit)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      paddr_reg  <= '0;
      nc_reg     <= 1'b0;
      size_reg   <= '0;
      sig_reg    <= '0;
      way_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (ack) begin
        paddr_reg <= miss_paddr_i;
        nc_reg    <= miss_nc_i;
        size_reg  <= miss_size_i;
        sig_reg   <= miss_signature_i;
        way_reg   <= victim_oh;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request: fields come from the captured registers, so they stay
  // stable for as long as mem_req_o is high. They read zero otherwise.
  // ---------------------------------------------------------------------------
  assign mem_req_o   = (state_reg == MEM_REQ);
  assign mem_paddr_o = !mem_req_o ? '0 :
                       nc_reg     ? paddr_reg :
                                    {paddr_reg[63:OffWidth], {OffWidth{1'b0}}};
  assign mem_size_o  = !mem_req_o ? 3'b000 : (nc_reg ? size_reg : 3'b111);
  assign mem_nc_o    = mem_req_o && nc_reg;
  assign mem_id_o    = mem_req_o ? RdTxId : '0;

  // ---------------------------------------------------------------------------
  // Return path: data outputs are zero outside their strobe.
  // ---------------------------------------------------------------------------
  logic [WordSelWidth-1:0] word_sel;
  assign word_sel = paddr_reg[3 +: WordSelWidth];

  assign miss_rtrn_vld_o  = rtrn_hit;
  assign miss_rtrn_data_o = rtrn_hit ? mem_rtrn_data_i[{word_sel, 6'd0} +: 64] : '0;

  assign wr_cl_vld_o  = refill;
  assign wr_cl_way_o  = refill ? way_reg : '0;
  assign wr_cl_idx_o  = refill ? paddr_reg[OffWidth +: DcacheClIdxWidth] : '0;
  assign wr_cl_tag_o  = refill ? paddr_reg[TagLsb +: DcacheTagWidth] : '0;
  assign wr_cl_sig_o  = refill ? sig_reg : '0;
  assign wr_cl_data_o = refill ? mem_rtrn_data_i : '0;

`ifdef WT_DCACHE_RD_MISS_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------------
  logic [31:0] perf_miss_cnt_reg, perf_replay_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_miss_cnt_reg   <= '0;
      perf_replay_cnt_reg <= '0;
    end else begin
      if (ack && (perf_miss_cnt_reg != '1)) begin
        perf_miss_cnt_reg <= perf_miss_cnt_reg + 32'd1;
      end
      if (replay && (perf_replay_cnt_reg != '1)) begin
        perf_replay_cnt_reg <= perf_replay_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_miss_cnt_o   = perf_miss_cnt_reg;
  assign perf_replay_cnt_o = perf_replay_cnt_reg;
`endif

endmodule

// File: tb/tb_wt_dcache_rd_miss_unit.sv
// -----------------------------------------------------------------------------
// Testbench for wt_dcache_rd_miss_unit.
// Directed scenarios first, then randomized misses. Expected values come from
// a behavioural model: the victim rule is applied by scanning the bits, and a
// round-robin counter stands in for the pointer.
// -----------------------------------------------------------------------------
module tb_wt_dcache_rd_miss_unit;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         miss_req_i;
  logic         miss_ack_o;
  logic         miss_replay_o;
  logic [63:0]  miss_paddr_i;
  logic         miss_nc_i;
  logic [2:0]   miss_size_i;
  logic [1:0]   miss_id_i;
  logic [3:0]   miss_vld_bits_i;
  logic [3:0]   miss_ever_hit_i;
  logic [13:0]  miss_signature_i;
  logic         miss_rtrn_vld_o;
  logic [63:0]  miss_rtrn_data_o;
  logic         wr_pend_vld_i;
  logic [7:0]   wr_pend_idx_i;
  logic         mem_req_o;
  logic         mem_ack_i;
  logic [63:0]  mem_paddr_o;
  logic [2:0]   mem_size_o;
  logic         mem_nc_o;
  logic [1:0]   mem_id_o;
  logic         mem_rtrn_vld_i;
  logic [1:0]   mem_rtrn_id_i;
  logic [127:0] mem_rtrn_data_i;
  logic         wr_cl_vld_o;
  logic [3:0]   wr_cl_way_o;
  logic [7:0]   wr_cl_idx_o;
  logic [43:0]  wr_cl_tag_o;
  logic [13:0]  wr_cl_sig_o;
  logic [127:0] wr_cl_data_o;
`ifdef WT_DCACHE_RD_MISS_PERF_EN
  logic [31:0]  perf_miss_cnt_o;
  logic [31:0]  perf_replay_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;
  int model_rr = 0;
  int perf_miss_exp   = 0;
  int perf_replay_exp = 0;

  always #5 clk_i = ~clk_i;

  wt_dcache_rd_miss_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .miss_req_i       (miss_req_i),
    .miss_ack_o       (miss_ack_o),
    .miss_replay_o    (miss_replay_o),
    .miss_paddr_i     (miss_paddr_i),
    .miss_nc_i        (miss_nc_i),
    .miss_size_i      (miss_size_i),
    .miss_id_i        (miss_id_i),
    .miss_vld_bits_i  (miss_vld_bits_i),
    .miss_ever_hit_i  (miss_ever_hit_i),
    .miss_signature_i (miss_signature_i),
    .miss_rtrn_vld_o  (miss_rtrn_vld_o),
    .miss_rtrn_data_o (miss_rtrn_data_o),
    .wr_pend_vld_i    (wr_pend_vld_i),
    .wr_pend_idx_i    (wr_pend_idx_i),
    .mem_req_o        (mem_req_o),
    .mem_ack_i        (mem_ack_i),
    .mem_paddr_o      (mem_paddr_o),
    .mem_size_o       (mem_size_o),
    .mem_nc_o         (mem_nc_o),
    .mem_id_o         (mem_id_o),
    .mem_rtrn_vld_i   (mem_rtrn_vld_i),
    .mem_rtrn_id_i    (mem_rtrn_id_i),
    .mem_rtrn_data_i  (mem_rtrn_data_i),
    .wr_cl_vld_o      (wr_cl_vld_o),
    .wr_cl_way_o      (wr_cl_way_o),
    .wr_cl_idx_o      (wr_cl_idx_o),
    .wr_cl_tag_o      (wr_cl_tag_o),
    .wr_cl_sig_o      (wr_cl_sig_o),
    .wr_cl_data_o     (wr_cl_data_o)
`ifdef WT_DCACHE_RD_MISS_PERF_EN
    ,
    .perf_miss_cnt_o  (perf_miss_cnt_o),
    .perf_replay_cnt_o(perf_replay_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] all_outputs();
    return {miss_ack_o, miss_replay_o, miss_rtrn_vld_o, miss_rtrn_data_o,
            mem_req_o, mem_paddr_o, mem_size_o, mem_nc_o, mem_id_o,
            wr_cl_vld_o, wr_cl_way_o, wr_cl_idx_o, wr_cl_tag_o, wr_cl_sig_o,
            wr_cl_data_o};
  endfunction

  // Victim rule: first invalid way, else first never-hit way, else the
  // round-robin way (which then advances only for cacheable misses).
  function automatic logic [3:0] model_victim(input logic [3:0] vld, input logic [3:0] eh,
                                              input logic nc);
    logic [3:0] w;
    for (int i = 0; i < 4; i++) if (!vld[i]) return 4'(1 << i);
    for (int i = 0; i < 4; i++) if (!eh[i])  return 4'(1 << i);
    w = 4'(1 << model_rr);
    if (!nc) model_rr = (model_rr + 1) % 4;
    return w;
  endfunction

  task automatic clear_inputs();
    miss_req_i = 0; miss_paddr_i = '0; miss_nc_i = 0; miss_size_i = '0; miss_id_i = 2'd1;
    miss_vld_bits_i = '0; miss_ever_hit_i = '0; miss_signature_i = '0;
    wr_pend_vld_i = 0; wr_pend_idx_i = '0; mem_ack_i = 0;
    mem_rtrn_vld_i = 0; mem_rtrn_id_i = '0; mem_rtrn_data_i = '0;
  endtask

  // One complete miss. req_wait = MEM_REQ cycles before mem_ack_i.
  // collide: first attempt hits a pending store. bogus: a wrong-ID return in
  // MEM_WAIT. hold: requester keeps miss_req_i high throughout. rst_wait:
  // reset in MEM_WAIT instead of returning data.
  task automatic do_miss(input logic [63:0] paddr, input logic nc, input logic [2:0] size,
                         input logic [3:0] vld, input logic [3:0] eh, input logic [13:0] sig,
                         input int req_wait, input bit collide, input bit bogus,
                         input bit hold, input bit rst_wait);
    logic [3:0]   way;
    logic [127:0] data;
    logic [63:0]  exp_addr;
    logic [2:0]   exp_size;
    exp_addr = nc ? paddr : {paddr[63:4], 4'h0};
    exp_size = nc ? size : 3'b111;
    data     = {$urandom, $urandom, $urandom, $urandom};

    @(negedge clk_i);
    miss_req_i = 1; miss_paddr_i = paddr; miss_nc_i = nc; miss_size_i = size;
    miss_vld_bits_i = vld; miss_ever_hit_i = eh; miss_signature_i = sig;
    if (collide) begin
      wr_pend_vld_i = 1; wr_pend_idx_i = paddr[11:4];
      #1;
      check("replay_pulse", miss_replay_o, 1'b1);
      check("replay_no_ack", miss_ack_o, 1'b0);
      check("replay_no_memreq", mem_req_o, 1'b0);
      perf_replay_exp++;
      @(negedge clk_i);
      wr_pend_vld_i = 0;
    end else begin
      // NC may match the pending index; cacheable uses a different one.
      wr_pend_vld_i = 1'($urandom_range(0, 1));
      wr_pend_idx_i = nc ? paddr[11:4] : paddr[11:4] ^ 8'h5a;
    end
    #1;
    check("ack_pulse", miss_ack_o, 1'b1);
    check("ack_no_replay", miss_replay_o, 1'b0);
    way = model_victim(vld, eh, nc);
    perf_miss_exp++;

    for (int c = 0; c <= req_wait; c++) begin
      @(negedge clk_i);
      if (c == 0) begin
        wr_pend_vld_i = 0;
        if (!hold) miss_req_i = 0;
      end
      mem_ack_i = (c == req_wait);
      // A return alongside mem_ack_i must be dropped.
      mem_rtrn_vld_i = (c == req_wait); mem_rtrn_id_i = 2'd1; mem_rtrn_data_i = data;
      #1;
      check("mem_req", mem_req_o, 1'b1);
      check("mem_paddr", mem_paddr_o, exp_addr);
      check("mem_size", mem_size_o, exp_size);
      check("mem_nc", mem_nc_o, nc);
      check("mem_id", mem_id_o, 2'd1);
      check("memreq_no_ack", miss_ack_o, 1'b0);
      check("early_rtrn_ignored", miss_rtrn_vld_o, 1'b0);
    end

    @(negedge clk_i);
    mem_ack_i = 0; mem_rtrn_vld_i = 0;
    if (rst_wait) begin
      rst_i = 1;
      @(negedge clk_i);
      rst_i = 0;
      model_rr = 0; perf_miss_exp = 0; perf_replay_exp = 0;
      miss_req_i = 0;
      mem_rtrn_vld_i = 1; mem_rtrn_id_i = 2'd1; mem_rtrn_data_i = data;
      #1;
      check("rst_outputs_zero", all_outputs(), '0);
      @(negedge clk_i);
      mem_rtrn_vld_i = 0;
      #1;
      check("rst_idle_zero", all_outputs(), '0);
      return;
    end
    if (bogus) begin
      mem_rtrn_vld_i = 1; mem_rtrn_id_i = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
      mem_rtrn_data_i = ~data;
      #1;
      check("bogus_id_no_rtrn", miss_rtrn_vld_o, 1'b0);
      check("bogus_id_no_wrcl", wr_cl_vld_o, 1'b0);
      check("wait_no_ack", miss_ack_o, 1'b0);
      @(negedge clk_i);
    end

    mem_rtrn_vld_i = 1; mem_rtrn_id_i = 2'd1; mem_rtrn_data_i = data;
    #1;
    check("rtrn_vld", miss_rtrn_vld_o, 1'b1);
    check("rtrn_data", miss_rtrn_data_o, paddr[3] ? data[127:64] : data[63:0]);
    check("wr_cl_vld", wr_cl_vld_o, !nc);
    check("rtrn_no_ack", miss_ack_o, 1'b0);
    if (!nc) begin
      check("wr_cl_way", wr_cl_way_o, way);
      check("wr_cl_idx", wr_cl_idx_o, paddr[11:4]);
      check("wr_cl_tag", wr_cl_tag_o, paddr[55:12]);
      check("wr_cl_sig", wr_cl_sig_o, sig);
      check("wr_cl_data", wr_cl_data_o, data);
    end

    @(negedge clk_i);
    mem_rtrn_vld_i = 0;
    #1;
    check("post_rtrn_no_memreq", mem_req_o, 1'b0);
    check("post_rtrn_pulse_end", miss_rtrn_vld_o, 1'b0);
    if (hold) begin
      // Back in IDLE: the held request is acked now; withdraw it before the
      // edge so no new transaction starts.
      check("held_req_acked_in_idle", miss_ack_o, 1'b1);
      miss_req_i = 0;
    end
    $display("txn paddr=%h nc=%0d way=%b wait=%0d coll=%0d bogus=%0d hold=%0d rst=%0d",
             paddr, nc, way, req_wait, collide, bogus, hold, rst_wait);
  endtask

  initial begin
    logic [3:0] v, e;
    logic       nc;
    clear_inputs();
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_outputs_zero", all_outputs(), '0);
    rst_i = 0;

    // cacheable miss, invalid way 2, upper word
    do_miss(64'h0000_0000_8000_1238, 0, 3'b011, 4'b1011, 4'b0000, 14'h1abc, 3, 0, 0, 0, 0);
    // never-hit fallback
    do_miss(64'h0000_0000_8000_2040, 0, 3'b011, 4'hf, 4'b1101, 14'h0123, 0, 0, 0, 0, 0);
    // round-robin: 0001, 0010, 0100
    for (int i = 0; i < 3; i++)
      do_miss(64'h0000_0000_8000_3000 + 64'(i * 16), 0, 3'b011, 4'hf, 4'hf, 14'(i), 1, 0, 0, 0, 0);
    // store collision then accept
    do_miss(64'h0000_0000_8000_4450, 0, 3'b011, 4'b0111, 4'h0, 14'h2222, 0, 1, 0, 0, 0);
    // NC miss with all ways valid+hit: pointer must not move
    do_miss(64'h0000_0000_1000_0004, 1, 3'b010, 4'hf, 4'hf, 14'h0, 2, 0, 0, 0, 0);
    // round-robin resumes at way 3
    do_miss(64'h0000_0000_8000_5008, 0, 3'b011, 4'hf, 4'hf, 14'h3333, 0, 0, 0, 0, 0);
    // wrong-ID return ignored, held request not acked until IDLE
    do_miss(64'h0000_0000_8000_6018, 0, 3'b011, 4'hf, 4'hf, 14'h0444, 1, 0, 1, 1, 0);
    // reset while waiting for the return
    do_miss(64'h0000_0000_8000_7020, 0, 3'b011, 4'hf, 4'hf, 14'h0555, 0, 0, 0, 0, 1);

    for (int t = 0; t < 40; t++) begin
      nc = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 1) == 0) ? 4'hf : 4'($urandom);
      e  = ($urandom_range(0, 1) == 0) ? 4'hf : 4'($urandom);
      do_miss({8'h00, $urandom, 24'($urandom)}, nc, 3'($urandom), v, e, 14'($urandom),
              $urandom_range(0, 3), !nc && ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 0);
    end

`ifdef WT_DCACHE_RD_MISS_PERF_EN
    #1;
    check("perf_miss_cnt", perf_miss_cnt_o, 32'(perf_miss_exp));
    check("perf_replay_cnt", perf_replay_cnt_o, 32'(perf_replay_exp));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wt_dcache_rd_miss_unit.md
Name: wt_dcache_rd_miss_unit

Overview:
- Responder side of the dcache read-port miss interface: accepts one miss from the read controller, arbitrates against in-flight write-path activity, picks a victim way, and issues the memory transaction.
- On return, raises the miss-return strobe and writes the refill line into the cache arrays.
- Sits between the read controller, the L1 data/tag memories and the memory adapter. Single outstanding read miss.

Parameters:
- RdTxId, 1, transaction ID expected on miss requests and used on memory requests/returns.
- NumWays, 4, associativity; width of valid/ever-hit/way vectors.
- LineWidth, 128, cache line width in bits.
- SigWidth, 14, width of the replacement signature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- miss_req_i  in  1  miss request, held until ack or replay
- miss_ack_o  out  1  miss accepted (1-cycle pulse)
- miss_replay_o  out  1  request collides; requester must replay (1-cycle pulse)
- miss_paddr_i  in  64  miss physical address
- miss_nc_i  in  1  non-cacheable request
- miss_size_i  in  3  size (3'b111 = line)
- miss_id_i  in  CACHE_ID_WIDTH  transaction ID
- miss_vld_bits_i  in  NumWays  valid bits at the missed index
- miss_ever_hit_i  in  NumWays  ever-hit bits at the missed index
- miss_signature_i  in  SigWidth  replacement signature
- miss_rtrn_vld_o  out  1  miss served (1-cycle pulse)
- miss_rtrn_data_o  out  64  64-bit word selected by paddr[3]
- wr_pend_vld_i  in  1  write path has an outstanding store
- wr_pend_idx_i  in  DCACHE_CL_IDX_WIDTH  index of that store
- mem_req_o  out  1  memory request, held until ack
- mem_ack_i  in  1  memory accepted the request
- mem_paddr_o  out  64  request address
- mem_size_o  out  3  request size
- mem_nc_o  out  1  non-cacheable flag
- mem_id_o  out  CACHE_ID_WIDTH  request ID
- mem_rtrn_vld_i  in  1  memory return valid
- mem_rtrn_id_i  in  CACHE_ID_WIDTH  return ID
- mem_rtrn_data_i  in  LineWidth  return data
- wr_cl_vld_o  out  1  refill write strobe
- wr_cl_way_o  out  NumWays  one-hot victim way
- wr_cl_idx_o  out  DCACHE_CL_IDX_WIDTH  refill index
- wr_cl_tag_o  out  DCACHE_TAG_WIDTH  refill tag
- wr_cl_sig_o  out  SigWidth  signature stored with the line
- wr_cl_data_o  out  LineWidth  refill data

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer 0, captured request registers 0.
- FSM states: IDLE, MEM_REQ, MEM_WAIT.
- IDLE, miss_req_i=1:
  - If the request is cacheable, wr_pend_vld_i=1 and wr_pend_idx_i equals the paddr index: miss_replay_o=1, no ack, stay IDLE.
  - Otherwise: miss_ack_o=1; capture paddr, nc, size, signature and victim way; go to MEM_REQ next cycle.
  - Ack and replay are never asserted together.
- Request while not in IDLE: ignored (no ack, no replay); the requester keeps holding it.
- Victim selection, computed combinationally at ack:
  - Lowest-index way with valid=0.
  - Else lowest-index way with ever_hit=0.
  - Else the way at the round-robin pointer. The pointer increments modulo NumWays only when this fallback is used and the request is cacheable.
- MEM_REQ:
  - mem_req_o=1; mem_id_o=RdTxId.
  - Cacheable: mem_paddr_o line-aligned (offset bits zero), mem_size_o=3'b111.
  - NC: exact paddr, mem_size_o=captured size.
  - On mem_ack_i, go to MEM_WAIT. Request fields are stable while mem_req_o is high.
- MEM_WAIT, on mem_rtrn_vld_i with mem_rtrn_id_i==RdTxId, same cycle:
  - miss_rtrn_vld_o=1 and miss_rtrn_data_o=selected 64-bit word.
  - If cacheable, also wr_cl_vld_o=1 with captured way/idx/tag/signature and the data.
  - Next state IDLE.
  - Returns with another ID are ignored.
- A return arriving in the same cycle as mem_ack_i is not accepted; it must arrive in MEM_WAIT.
- NC misses never assert wr_cl_vld_o and never advance the pointer.
- Kill of the request by the core is not visible here: the unit always completes the transaction; the requester absorbs it.
- Reset mid-transaction: immediate return to IDLE. A late memory return while IDLE is ignored.
- Minimum latency ack→rtrn_vld: 2 cycles (mem_ack_i in the cycle after ack, return in the following cycle).

Optional Feature:
- Macro: WT_DCACHE_RD_MISS_PERF_EN.
- Defined: adds outputs perf_miss_cnt_o[31:0] (increments on each ack) and perf_replay_cnt_o[31:0] (increments on each replay pulse). Both are saturating and reset to 0.
- Undefined: no counters and no perf ports.

Test Plan:
- Cacheable miss: paddr 0x8000_1238, vld_bits 4'b1011, mem_ack after 3 cycles, return ID=1. Expect ack pulse; mem_paddr_o=0x8000_1230, size 3'b111; on return, rtrn_vld and wr_cl_vld together, wr_cl_way_o=4'b0100, miss_rtrn_data_o=data[127:64].
- Victim fallback: vld_bits 4'hF with ever_hit 4'b1101 → way 4'b0010. Then three consecutive misses with vld 4'hF and ever_hit 4'hF → ways 0001, 0010, 0100.
- Collision: wr_pend_vld_i=1 with matching index → replay pulse, no ack, no mem_req. Next cycle wr_pend_vld_i=0 → ack.
- NC miss: nc=1, size 3'b010, paddr 0x1000_0004. Expect mem_paddr_o=0x1000_0004, size 3'b010; rtrn_vld asserted, wr_cl_vld stays 0.
- Return with ID≠RdTxId in MEM_WAIT is ignored; a later ID=1 return completes. A second miss_req_i during MEM_WAIT gets no ack until the unit is back in IDLE.
- rst_i asserted in MEM_WAIT: next cycle all outputs 0 and FSM in IDLE; a subsequent stray return produces no rtrn_vld and no wr_cl_vld.
